mem_arbiter: RTL and testbench

- Shares the single data-memory port (read_enable, write_enable, address, data, out) among up to NUM_REQ requesters, such as the CPU datapath, a program loader and a debug port.
- Round-robin arbitration with an optional per-requester lock that keeps the port for back-to-back bursts.
- Sequences each transfer as issue, then wait for memory latency, then complete. Returns read data and a one-cycle done pulse to the winning requester.

---
 rtl/mem_arbiter_if.sv | 29 ++
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of the shared data-memory arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req;
   logic [NUM_REQ-1:0]   we;
   logic [NUM_REQ-1:0]   lock;
   logic [NUM_REQ*8-1:0] addr;
   logic [NUM_REQ*8-1:0] wdata;
   logic [NUM_REQ-1:0]   gnt;
   logic [NUM_REQ-1:0]   done;
   logic [7:0]           rdata;
   logic                 mem_read_enable;
   logic                 mem_write_enable;
   logic [7:0]           mem_address;
   logic [7:0]           mem_data;
   logic [7:0]           mem_out;

   modport slave (
      input  req, we, lock, addr, wdata, mem_out,
      output gnt, done, rdata, mem_read_enable, mem_write_enable, mem_address, mem_data
   );

   modport master (
      output req, we, lock, addr, wdata, mem_out,
      input  gnt, done, rdata, mem_read_enable, mem_write_enable, mem_address, mem_data
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with burst-limited lock, sharing one data-memory port.
// Each transfer runs IDLE -> ACCESS -> WAIT (MEM_LATENCY cycles) -> DONE.
module mem_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned MEM_LATENCY = 1,
   parameter int unsigned MAX_BURST   = 4
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);
   localparam int unsigned IW = $clog2(NUM_REQ);
   localparam int unsigned CW = IW + 1;
   localparam int unsigned BW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] NumReqW   = CW'(NUM_REQ);
   localparam logic [BW-1:0] MaxBurstW = BW'(MAX_BURST);
   localparam logic [3:0]    LatW      = 4'(MEM_LATENCY);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StAccess = 2'd1;
   localparam logic [1:0] StWait   = 2'd2;
   localparam logic [1:0] StDone   = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [IW-1:0]      rr_last_q, rr_last_d;
   logic [IW-1:0]      win_q, win_d;
   logic               we_q, we_d;
   logic [7:0]         addr_q, addr_d;
   logic [7:0]         wdata_q, wdata_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [7:0]         rdata_q, rdata_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [BW-1:0]      burst_q, burst_d;
   logic               lock_valid_q, lock_valid_d;
   logic [IW-1:0]      lock_owner_q, lock_owner_d;

   logic               rr_found;
   logic [IW-1:0]      rr_idx;
   logic [CW-1:0]      cand;
   logic               pick_valid;
   logic [IW-1:0]      pick_idx;

   // Scan from rr_last+1 upward, wrapping at NUM_REQ (which need not be a power of two).
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      cand     = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = CW'(rr_last_q) + CW'(k);
         if (cand >= NumReqW) cand = cand - NumReqW;
         if (!rr_found && bus.req[cand[IW-1:0]]) begin
            rr_found = 1'b1;
            rr_idx   = cand[IW-1:0];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_last_d    = rr_last_q;
      win_d        = win_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      gnt_d        = gnt_q;
      rdata_d      = rdata_q;
      cnt_d        = cnt_q;
      burst_d      = burst_q;
      lock_valid_d = lock_valid_q;
      lock_owner_d = lock_owner_q;
      pick_valid   = 1'b0;
      pick_idx     = '0;

      case (state_q)
         StIdle: begin
            // burst_q counts every grant of the current streak, including the first one.
            if (lock_valid_q && bus.req[lock_owner_q] && (burst_q < MaxBurstW)) begin
               pick_valid = 1'b1;
               pick_idx   = lock_owner_q;
               burst_d    = burst_q + BW'(1);
            end else begin
               lock_valid_d = 1'b0;
               burst_d      = '0;
               if (rr_found) begin
                  pick_valid = 1'b1;
                  pick_idx   = rr_idx;
                  burst_d    = BW'(1);
               end
            end
            if (pick_valid) begin
               win_d     = pick_idx;
               we_d      = bus.we[pick_idx];
               addr_d    = bus.addr[{pick_idx, 3'b000} +: 8];
               wdata_d   = bus.wdata[{pick_idx, 3'b000} +: 8];
               gnt_d     = NUM_REQ'(1) << pick_idx;
               rr_last_d = pick_idx;
               state_d   = StAccess;
            end else begin
               gnt_d = '0;
            end
         end
         StAccess: begin
            cnt_d   = LatW;
            state_d = (MEM_LATENCY > 0) ? StWait : StDone;
         end
         StWait: begin
            if (cnt_q <= 4'd1) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDone: begin
            if (!we_q) rdata_d = bus.mem_out;
            lock_valid_d = bus.lock[win_q];
            lock_owner_d = win_q;
            gnt_d        = '0;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         rr_last_q    <= IW'(NUM_REQ - 1);
         win_q        <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         gnt_q        <= '0;
         rdata_q      <= '0;
         cnt_q        <= '0;
         burst_q      <= '0;
         lock_valid_q <= 1'b0;
         lock_owner_q <= '0;
      end else begin
         state_q      <= state_d;
         rr_last_q    <= rr_last_d;
         win_q        <= win_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         gnt_q        <= gnt_d;
         rdata_q      <= rdata_d;
         cnt_q        <= cnt_d;
         burst_q      <= burst_d;
         lock_valid_q <= lock_valid_d;
         lock_owner_q <= lock_owner_d;
      end
   end

   assign bus.gnt              = gnt_q;
   assign bus.done             = (state_q == StDone) ? (NUM_REQ'(1) << win_q) : '0;
   assign bus.rdata            = rdata_q;
   assign bus.mem_read_enable  = (state_q == StAccess) && !we_q;
   assign bus.mem_write_enable = (state_q == StAccess) && we_q;
   assign bus.mem_address      = addr_q;
   assign bus.mem_data         = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: three instances (latency 1, 3 and 0) share one
// stimulus set and one memory model; only the selected instance is out of reset.
module tb_mem_arbiter;
   typedef struct {
      int         idx;
      bit         rd;
      logic [7:0] rdata;
      int         cyc;
   } done_exp_t;

   typedef struct {
      bit         wr;
      logic [7:0] addr;
      logic [7:0] data;
   } mem_exp_t;

   logic        clk;
   logic        rst_a, rst_b, rst_c;
   int          sel;
   int          cyc;
   int          total, bad;
   logic [3:0]  req, we, lock;
   logic [31:0] addr, wdata;
   logic [7:0]  mem [256];

   done_exp_t sb_q[$];
   mem_exp_t  mem_q[$];

   logic [3:0] gnt_m, done_m;
   logic [7:0] rdata_m, addr_m, data_m;
   logic       rd_m, wr_m;

   mem_arbiter_if #(.NUM_REQ(4)) ifa ();
   mem_arbiter_if #(.NUM_REQ(4)) ifb ();
   mem_arbiter_if #(.NUM_REQ(4)) ifc ();

   mem_arbiter #(.NUM_REQ(4), .MEM_LATENCY(1), .MAX_BURST(2)) u_a (
      .clk(clk), .reset(rst_a), .bus(ifa)
   );
   mem_arbiter #(.NUM_REQ(4), .MEM_LATENCY(3), .MAX_BURST(2)) u_b (
      .clk(clk), .reset(rst_b), .bus(ifb)
   );
   mem_arbiter #(.NUM_REQ(4), .MEM_LATENCY(0), .MAX_BURST(2)) u_c (
      .clk(clk), .reset(rst_c), .bus(ifc)
   );

   assign ifa.req = req;   assign ifb.req = req;   assign ifc.req = req;
   assign ifa.we = we;     assign ifb.we = we;     assign ifc.we = we;
   assign ifa.lock = lock; assign ifb.lock = lock; assign ifc.lock = lock;
   assign ifa.addr = addr; assign ifb.addr = addr; assign ifc.addr = addr;
   assign ifa.wdata = wdata; assign ifb.wdata = wdata; assign ifc.wdata = wdata;
   assign ifa.mem_out = mem[ifa.mem_address];
   assign ifb.mem_out = mem[ifb.mem_address];
   assign ifc.mem_out = mem[ifc.mem_address];

   always_comb begin
      gnt_m = ifa.gnt; done_m = ifa.done; rdata_m = ifa.rdata;
      rd_m = ifa.mem_read_enable; wr_m = ifa.mem_write_enable;
      addr_m = ifa.mem_address; data_m = ifa.mem_data;
      if (sel == 1) begin
         gnt_m = ifb.gnt; done_m = ifb.done; rdata_m = ifb.rdata;
         rd_m = ifb.mem_read_enable; wr_m = ifb.mem_write_enable;
         addr_m = ifb.mem_address; data_m = ifb.mem_data;
      end else if (sel == 2) begin
         gnt_m = ifc.gnt; done_m = ifc.done; rdata_m = ifc.rdata;
         rd_m = ifc.mem_read_enable; wr_m = ifc.mem_write_enable;
         addr_m = ifc.mem_address; data_m = ifc.mem_data;
      end
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: preloaded contents, write on the enable edge.
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      mem[8'h20] = 8'h5A;
      mem[8'h33] = 8'h77;
      for (int i = 0; i < 4; i++) mem[8'h40 + i] = 8'hA0 + 8'(i);
      forever begin
         @(posedge clk);
         if (wr_m) mem[addr_m] <= data_m;
      end
   end

   // Done monitor: every done pulse pops one expected completion.
   initial begin
      done_exp_t  e;
      bit         chk_rd;
      logic [7:0] want_rd;
      chk_rd = 1'b0;
      forever begin
         @(negedge clk);
         if (chk_rd) begin
            chk_rd = 1'b0;
            total++;
            if (rdata_m !== want_rd) begin
               bad++;
               $display("FAIL rdata got=%h want=%h", rdata_m, want_rd);
            end
         end
         if (gnt_m != 4'b0 && !$onehot(gnt_m)) begin
            total++; bad++;
            $display("FAIL gnt_onehot got=%b", gnt_m);
         end
         if (done_m != 4'b0) begin
            total++;
            if (sb_q.size() == 0) begin
               bad++;
               $display("FAIL done_unexpected got=%b want=none", done_m);
            end else begin
               e = sb_q.pop_front();
               if (done_m !== 4'(1 << e.idx)) begin
                  bad++;
                  $display("FAIL done_idx got=%b want=%b", done_m, 4'(1 << e.idx));
               end
               total++;
               if (gnt_m !== done_m) begin
                  bad++;
                  $display("FAIL gnt_in_done got=%b want=%b", gnt_m, done_m);
               end
               if (e.cyc >= 0) begin
                  total++;
                  if (cyc != e.cyc) begin
                     bad++;
                     $display("FAIL done_latency got_cyc=%0d want_cyc=%0d", cyc, e.cyc);
                  end
               end
               if (e.rd) begin
                  chk_rd  = 1'b1;
                  want_rd = e.rdata;
               end
            end
         end
      end
   end

   // Memory-port monitor: every enable cycle pops one expected access.
   initial begin
      mem_exp_t m;
      forever begin
         @(negedge clk);
         if (rd_m || wr_m) begin
            total++;
            if (mem_q.size() == 0) begin
               bad++;
               $display("FAIL mem_unexpected rd=%0b wr=%0b addr=%h want=none", rd_m, wr_m, addr_m);
            end else begin
               m = mem_q.pop_front();
               if ((rd_m == wr_m) || (wr_m != m.wr) || (addr_m != m.addr) ||
                   (m.wr && (data_m != m.data))) begin
                  bad++;
                  $display("FAIL mem_access got rd=%0b wr=%0b addr=%h data=%h want wr=%0b addr=%h data=%h",
                           rd_m, wr_m, addr_m, data_m, m.wr, m.addr, m.data);
               end
            end
         end
      end
   end

   task automatic wait_dones(input int n, input int budget);
      int seen = 0;
      int cycles = 0;
      while (seen < n && cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (done_m != 4'b0) seen++;
      end
      total++;
      if (seen < n) begin
         bad++;
         $display("FAIL wait_dones got=%0d want=%0d", seen, n);
      end
   endtask

   task automatic push_rd(input int idx);
      done_exp_t e;
      mem_exp_t  m;
      e.idx = idx; e.rd = 1'b1; e.rdata = 8'hA0 + 8'(idx); e.cyc = -1;
      m.wr = 1'b0; m.addr = 8'h40 + 8'(idx); m.data = 8'h00;
      sb_q.push_back(e);
      mem_q.push_back(m);
   endtask

   task automatic single(input int idx, input bit wr, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] exp_rd, input int lat);
      done_exp_t e;
      mem_exp_t  m;
      addr[8*idx +: 8]  = a;
      wdata[8*idx +: 8] = d;
      we[idx]           = wr;
      m.wr = wr; m.addr = a; m.data = d;
      mem_q.push_back(m);
      e.idx = idx; e.rd = !wr; e.rdata = exp_rd; e.cyc = cyc + lat + 2;
      sb_q.push_back(e);
      req[idx] = 1'b1;
      wait_dones(1, 30);
      req[idx] = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic set_rd_addrs();
      for (int i = 0; i < 4; i++) addr[8*i +: 8] = 8'h40 + 8'(i);
      we = 4'b0000;
   endtask

   task automatic reset_a();
      rst_a = 1'b1;
      repeat (2) @(negedge clk);
      rst_a = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int        rr_order [6];
      int        lk_order [6];
      mem_exp_t  m;
      done_exp_t e;
      rr_order = '{0, 1, 2, 3, 0, 1};
      lk_order = '{2, 2, 0, 2, 2, 0};
      total = 0; bad = 0; cyc = 0; sel = 0;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      req = '0; we = '0; lock = '0; addr = '0; wdata = '0;

      repeat (3) @(negedge clk);
      total++;
      if (gnt_m !== 4'b0 || done_m !== 4'b0 || rdata_m !== 8'h00) begin
         bad++;
         $display("FAIL reset_req_side gnt=%b done=%b rdata=%h want=0", gnt_m, done_m, rdata_m);
      end
      total++;
      if (rd_m !== 1'b0 || wr_m !== 1'b0 || addr_m !== 8'h00 || data_m !== 8'h00) begin
         bad++;
         $display("FAIL reset_mem_side rd=%b wr=%b addr=%h data=%h want=0", rd_m, wr_m, addr_m, data_m);
      end
      rst_a = 1'b0;
      repeat (2) @(negedge clk);

      // Single read, then write/read-back, on the latency-1 instance.
      single(1, 1'b0, 8'h20, 8'h00, 8'h5A, 1);
      single(0, 1'b1, 8'h10, 8'h3C, 8'h00, 1);
      single(0, 1'b0, 8'h10, 8'h00, 8'h3C, 1);

      // Round robin with all requests held.
      reset_a();
      set_rd_addrs();
      for (int i = 0; i < 6; i++) push_rd(rr_order[i]);
      req = 4'b1111;
      wait_dones(6, 60);
      req = 4'b0000;
      repeat (4) @(negedge clk);

      // Lock on requester 2 with a two-grant burst limit.
      reset_a();
      set_rd_addrs();
      lock = 4'b0100;
      for (int i = 0; i < 6; i++) push_rd(lk_order[i]);
      req[2] = 1'b1;
      @(negedge clk);
      req[0] = 1'b1;
      wait_dones(6, 60);
      req  = 4'b0000;
      lock = 4'b0000;
      repeat (4) @(negedge clk);

      // Reset in WAIT on the latency-3 instance.
      rst_a = 1'b1;
      repeat (2) @(negedge clk);
      sel = 1;
      rst_b = 1'b0;
      repeat (2) @(negedge clk);
      addr[7:0] = 8'h20;
      m.wr = 1'b0; m.addr = 8'h20; m.data = 8'h00;
      mem_q.push_back(m);
      req[0] = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (gnt_m !== 4'b0001) begin
         bad++;
         $display("FAIL wait_gnt got=%b want=0001", gnt_m);
      end
      rst_b  = 1'b1;
      req[0] = 1'b0;
      @(negedge clk);
      total++;
      if (gnt_m !== 4'b0 || done_m !== 4'b0 || rd_m !== 1'b0 || wr_m !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid gnt=%b done=%b rd=%b wr=%b want=0", gnt_m, done_m, rd_m, wr_m);
      end
      rst_b = 1'b0;
      repeat (10) @(negedge clk);
      set_rd_addrs();
      push_rd(0);
      push_rd(1);
      req = 4'b0011;
      wait_dones(2, 40);
      req = 4'b0000;
      repeat (4) @(negedge clk);

      // Zero latency on the third instance.
      rst_b = 1'b1;
      repeat (2) @(negedge clk);
      sel = 2;
      rst_c = 1'b0;
      repeat (2) @(negedge clk);
      single(3, 1'b0, 8'h33, 8'h00, 8'h77, 0);

      repeat (5) @(negedge clk);
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         e = sb_q[0];
         $display("FAIL sb_leftover got=%0d want=0 (first idx=%0d)", sb_q.size(), e.idx);
      end
      total++;
      if (mem_q.size() != 0) begin
         bad++;
         $display("FAIL mem_leftover got=%0d want=0", mem_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end
endmodule
